// File: rtl/axis_extremum_pkg.sv
// Shared types and constants for the extremum-finder scheduler and its range decider.
package axis_extremum_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        MEASURE = 3'd2,
        EVAL    = 3'd3,
        SETTLE  = 3'd4
    } sched_state_t;

    localparam int         LOG_COUNT_W  = 5;
    localparam logic [2:0] SHIFT_MAX    = 3'd7;
    localparam int         WATCHDOG_PAD = 16;
    localparam int         WATCHDOG_W   = 34;

    // Cycles a window may take before the finder is considered stuck: 2^(cfg+1) + pad.
    function automatic logic [WATCHDOG_W-1:0] watchdog_limit(input logic [LOG_COUNT_W-1:0] cfg);
        logic [5:0] exp_bits;
        exp_bits = {1'b0, cfg} + 6'd1;
        return (WATCHDOG_W'(1) << exp_bits) + WATCHDOG_W'(WATCHDOG_PAD);
    endfunction

endpackage

// File: rtl/extremum_range_decider.sv
// Combinational auto-range decision: saturating |min|/|max|, peak select, and a
// one-step shift adjustment against unsigned hi/lo thresholds.
module extremum_range_decider
    import axis_extremum_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] ext_min,
    input  logic [W-1:0] ext_max,
    input  logic [W-1:0] thresh_hi,
    input  logic [W-1:0] thresh_lo,
    input  logic [2:0]   shift,
    output logic [2:0]   next_shift
);

    // The most negative value has no positive twin; clamp it to the most positive.
    function automatic logic [W-1:0] sat_abs(input logic [W-1:0] x);
        if (x == {1'b1, {(W-1){1'b0}}})
            return {1'b0, {(W-1){1'b1}}};
        else if (x[W-1])
            return -x;
        else
            return x;
    endfunction

    logic [W-1:0] abs_min;
    logic [W-1:0] abs_max;
    logic [W-1:0] peak;

    assign abs_min = sat_abs(ext_min);
    assign abs_max = sat_abs(ext_max);
    assign peak    = (abs_min > abs_max) ? abs_min : abs_max;

    always_comb begin
        next_shift = shift;
        if (peak > thresh_hi && shift < SHIFT_MAX)
            next_shift = shift + 3'd1;
        else if (peak < thresh_lo && shift != 3'd0)
            next_shift = shift - 3'd1;
    end

endmodule

// File: rtl/axis_extremum_scheduler.sv
// Arms extremum-finder windows, captures each min/max result and, when built with
// EXTREMUM_AUTO_RANGE_EN, steps the finder shift from the observed peak.
module axis_extremum_scheduler
    import axis_extremum_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int SETTLE_WIDTH     = 16
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        enable,
    input  logic [4:0]                  log_count_cfg,
    input  logic [2:0]                  shift_cfg,
    input  logic [AXIS_TDATA_WIDTH-1:0] thresh_hi,
    input  logic [AXIS_TDATA_WIDTH-1:0] thresh_lo,
    input  logic [SETTLE_WIDTH-1:0]     settle_cycles,
    input  logic [AXIS_TDATA_WIDTH-1:0] ext_min,
    input  logic [AXIS_TDATA_WIDTH-1:0] ext_max,
    input  logic                        ext_valid,
    output logic [4:0]                  log_count,
    output logic [2:0]                  shift,
    output logic [AXIS_TDATA_WIDTH-1:0] min_out,
    output logic [AXIS_TDATA_WIDTH-1:0] max_out,
    output logic [2:0]                  result_shift,
    output logic                        result_valid,
    output logic [15:0]                 window_count,
    output logic                        busy,
    output logic                        timeout_flag,
    output logic [2:0]                  fsm_state
);

    // Handshake: ext_valid is a single-cycle strobe with no back-pressure; it is
    // accepted only in MEASURE while enable is high, and result_valid answers it
    // one cycle later as a single-cycle strobe alongside the captured data.

    sched_state_t            state_q;
    sched_state_t            state_nx;
    logic [LOG_COUNT_W-1:0]  cfg_q;
    logic [WATCHDOG_W-1:0]   wdog_q;
    logic                    capture;
    logic                    timeout;
    logic                    shift_change;
    logic                    settle_done;
    logic [2:0]              next_shift;

`ifdef EXTREMUM_AUTO_RANGE_EN
    logic [AXIS_TDATA_WIDTH-1:0] thresh_hi_q;
    logic [AXIS_TDATA_WIDTH-1:0] thresh_lo_q;
    logic [SETTLE_WIDTH-1:0]     settle_q;
    logic [SETTLE_WIDTH-1:0]     settle_cnt_q;

    extremum_range_decider #(
        .W (AXIS_TDATA_WIDTH)
    ) u_decider (
        .ext_min    (min_out),
        .ext_max    (max_out),
        .thresh_hi  (thresh_hi_q),
        .thresh_lo  (thresh_lo_q),
        .shift      (shift),
        .next_shift (next_shift)
    );

    assign shift_change = (next_shift != shift);
    assign settle_done  = (settle_cnt_q == settle_q);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            thresh_hi_q  <= '0;
            thresh_lo_q  <= '0;
            settle_q     <= '0;
            settle_cnt_q <= '0;
        end else begin
            if (state_q == ARM) begin
                thresh_hi_q <= thresh_hi;
                thresh_lo_q <= thresh_lo;
                settle_q    <= settle_cycles;
            end
            settle_cnt_q <= (state_q == SETTLE) ? settle_cnt_q + 1'b1 : '0;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg   = ^{thresh_hi, thresh_lo, settle_cycles};
    assign next_shift   = shift;
    assign shift_change = 1'b0;
    assign settle_done  = 1'b1;
`endif

    always_comb begin
        state_nx  = state_q;
        log_count = '0;
        capture   = 1'b0;
        timeout   = 1'b0;
        case (state_q)
            IDLE: begin
                if (log_count_cfg != '0)
                    state_nx = ARM;
            end
            ARM: begin
                log_count = log_count_cfg;
                state_nx  = (log_count_cfg != '0) ? MEASURE : IDLE;
            end
            MEASURE: begin
                log_count = cfg_q;
                if (ext_valid) begin
                    capture  = 1'b1;
                    state_nx = EVAL;
                end else if (wdog_q == watchdog_limit(cfg_q) - WATCHDOG_W'(1)) begin
                    // Zero for one cycle so the finder restarts from scratch.
                    timeout   = 1'b1;
                    log_count = '0;
                    state_nx  = ARM;
                end
            end
            EVAL: begin
                log_count = cfg_q;
                state_nx  = shift_change ? SETTLE : MEASURE;
            end
            SETTLE: begin
                if (settle_done)
                    state_nx = ARM;
            end
            default: state_nx = IDLE;
        endcase
        if (!enable) begin
            state_nx  = IDLE;
            log_count = '0;
            capture   = 1'b0;
            timeout   = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            cfg_q        <= '0;
            shift        <= '0;
            wdog_q       <= '0;
            min_out      <= '0;
            max_out      <= '0;
            result_shift <= '0;
            result_valid <= 1'b0;
            window_count <= '0;
            timeout_flag <= 1'b0;
        end else begin
            state_q      <= state_nx;
            result_valid <= capture;
            if (state_q == ARM)
                cfg_q <= log_count_cfg;
            if (state_q == IDLE && state_nx == ARM)
                shift <= shift_cfg;
            else if (state_q == EVAL && state_nx == SETTLE)
                shift <= next_shift;
            // Restarted for every window, including back-to-back ones after EVAL.
            wdog_q <= (state_q == MEASURE) ? wdog_q + 1'b1 : '0;
            if (timeout)
                timeout_flag <= 1'b1;
            if (capture) begin
                min_out      <= ext_min;
                max_out      <= ext_max;
                result_shift <= shift;
                window_count <= window_count + 16'd1;
            end
        end
    end

    assign busy      = (state_q != IDLE);
    assign fsm_state = state_q;

endmodule
